i2c_target_rx: RTL and testbench
================================

# i2c_target_rx

Receive-only I2C target that consumes the SDA/SCL pair produced by the team's I2C master and delivers addressed write bytes to the local fabric. It samples the open-drain bus with a fast system clock, detects START/STOP, and matches a 7-bit address. It ACKs the address and each data byte by pulling SDA low, and presents each received byte on a valid/ready handshake.

## Interface
- `TARGET_ADDR`, default 7'h2B: 7-bit address this target answers to.
- `clk` input 1: system clock, at least 8x the SCL rate.
- `reset` input 1: asynchronous, active-low reset.
- `scl_in` input 1: bus SCL, asynchronous to `clk`.
- `sda_in` input 1: bus SDA, asynchronous to `clk`.
- `sda_oe` output 1: 1 pulls SDA low (ACK); 0 releases.
- `rx_data` output 8: last received byte, MSB first on the bus.
- `rx_valid` output 1: one-cycle pulse when `rx_data` is updated.
- `rx_ready` input 1: sink can accept a byte; sampled when a byte completes.
- `busy` output 1: high from START to STOP, including non-matching transfers.
- `addr_match` output 1: high from address ACK until STOP or repeated START.

## Operation
- `scl_in`/`sda_in` pass through 2-flop synchronizers, then a 1-flop history register for edge detection.
- START condition: SDA falling while SCL is high. STOP condition: SDA rising while SCL is high. Both are valid in any state.
- On START or repeated START:
  - bit counter cleared;
  - `addr_match` cleared;
  - next state is ADDR.
- On STOP: go to IDLE, `busy`=0, `addr_match`=0, `sda_oe`=0.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: wait for START.
- ADDR: shift 8 bits (7 address bits MSB first, then R/W) on each synchronized SCL rising edge. On the SCL falling edge after bit 8:
  - address equals `TARGET_ADDR` and R/W=0: assert `sda_oe`, go to ADDR_ACK;
  - any other address, or R/W=1: `sda_oe` stays 0, go to IGNORE.
- ADDR_ACK: hold `sda_oe` through the ACK SCL high phase. On the next SCL falling edge release `sda_oe`, set `addr_match`=1, go to DATA.
- DATA: shift 8 bits on SCL rising edges. On the SCL falling edge after bit 8:
  - `rx_ready`=1: load `rx_data`, pulse `rx_valid`, assert `sda_oe`, go to DATA_ACK;
  - `rx_ready`=0: no load, no pulse, NACK, go to IGNORE.
- DATA_ACK: release `sda_oe` on the next SCL falling edge and return to DATA. Unlimited bytes per transfer.
- IGNORE: `sda_oe`=0; leave only on STOP or START.
- A STOP or START in mid-byte discards the partial byte. No `rx_valid` is issued for it.
- Simultaneous SCL edge and START/STOP detection in the same cycle is impossible: START/STOP require SCL high and stable. START/STOP take priority over bit sampling.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `addr_match`=0, state IDLE.
- Reset asserted mid-transfer releases SDA within the same cycle; the block resumes only after a fresh START.
- Bus-to-internal latency is 3 `clk` cycles: 2 sync + 1 edge detect.
- `sda_oe` rises 1 `clk` after the detected SCL falling edge. It therefore changes only while SCL is low.
- `rx_valid` is exactly 1 cycle wide and coincident with the `rx_data` update.
- `rx_ready` is sampled in that same cycle only; it need not be held afterwards.
- `busy` rises 1 cycle after START detection and falls 1 cycle after STOP detection.

## Structure
- Shared package `i2c_pkg`:
  - state encoding localparams;
  - `I2C_ADDR_W`=7;
  - `I2C_BYTE_W`=8;
  - default address 7'h2B, shared with the master's address constant.
- One sub-module, `i2c_bus_sync`: synchronizers plus edge/START/STOP detection.
  - Outputs: `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.
  - Reused later by a master-side arbitration monitor.
- Top module holds the FSM, the 3-bit bit counter, the shift register and the output registers.

## Test plan
- START, address 0x2B+W (byte 0x56), data 0x59, STOP with `rx_ready`=1 → both ACK bits are 0 on the bus, one `rx_valid` with `rx_data`=0x59, `busy` falls after STOP.
- Address 0x2A+W then data 0x59 → `sda_oe` never asserts, no `rx_valid`, `busy` still high until STOP, `addr_match`=0.
- Address 0x2B+R (0x57) → NACK (SDA high in ACK slot), IGNORE until STOP, no `rx_valid`.
- 0x2B+W, data 0x59 with `rx_ready`=0 → data NACKed, `rx_data` stays at its prior value, no pulse. A following byte 0xA5 is ignored until STOP.
- 0x2B+W, data 0x59, 0x3C, repeated START, 0x2B+W, 0x81, STOP → three `rx_valid` pulses, in order 0x59, 0x3C, 0x81.
- Reset asserted after 4 data bits of 0x59 → `sda_oe`=0 and all outputs at reset values immediately. A subsequent full 0x2B+W/0x59 transfer is received correctly.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target receiver and the master side.
// Holds bus field widths, the default target address (also used by the
// master as its address constant) and the receiver state encoding.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'h2B;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and detects bus events.
// Ports:
//   clk, reset      system clock, async active-low reset
//   scl_in, sda_in  raw bus lines (asynchronous)
//   scl_rise/fall   one-cycle pulses on synchronized SCL edges
//   start_det       SDA falling while SCL high and stable
//   stop_det        SDA rising while SCL high and stable
//   sda_s           synchronized SDA level
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;
    logic       scl_s;

    // Reset to the idle-bus level so leaving reset never fakes an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_s & ~scl_d;
    assign scl_fall  = ~scl_s &  scl_d;
    // SCL must be high in both samples, so an SCL edge can never be
    // mistaken for START/STOP.
    assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
    assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
// Receive-only I2C target. Matches a 7-bit address (write only), ACKs the
// address and each data byte, and hands bytes to the fabric with a
// one-cycle rx_valid pulse. A byte is NACKed if rx_ready is low when it
// completes, after which the rest of the transfer is ignored.
// Ports:
//   clk, reset       system clock (>= 8x SCL), async active-low reset
//   scl_in, sda_in   bus lines
//   sda_oe           1 pulls SDA low (ACK)
//   rx_data/valid    received byte and its update strobe
//   rx_ready         sink ready, sampled when a byte completes
//   busy             START..STOP
//   addr_match       address ACK..STOP / repeated START
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = I2C_DEFAULT_ADDR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  addr_match
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_state_e            state, state_nxt;
    logic [2:0]            bit_cnt, bit_cnt_nxt;
    logic                  byte_full, byte_full_nxt;
    logic [I2C_BYTE_W-1:0] shreg, shreg_nxt;
    logic [I2C_BYTE_W-1:0] rx_data_nxt;
    logic                  sda_oe_nxt, rx_valid_nxt, addr_match_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            byte_full  <= 1'b0;
            shreg      <= '0;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            byte_full  <= byte_full_nxt;
            shreg      <= shreg_nxt;
            sda_oe     <= sda_oe_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            addr_match <= addr_match_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        byte_full_nxt  = byte_full;
        shreg_nxt      = shreg;
        sda_oe_nxt     = sda_oe;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        addr_match_nxt = addr_match;

        if (stop_det) begin
            state_nxt      = ST_IDLE;
            bit_cnt_nxt    = '0;
            byte_full_nxt  = 1'b0;
            sda_oe_nxt     = 1'b0;
            addr_match_nxt = 1'b0;
        end else if (start_det) begin
            state_nxt      = ST_ADDR;
            bit_cnt_nxt    = '0;
            byte_full_nxt  = 1'b0;
            sda_oe_nxt     = 1'b0;
            addr_match_nxt = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_DATA: begin
                    // byte_full marks 8 bits shifted; the decision waits for
                    // the following SCL fall so sda_oe only moves with SCL low.
                    if (scl_rise && !byte_full) begin
                        shreg_nxt   = {shreg[I2C_BYTE_W-2:0], sda_s};
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            byte_full_nxt = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        byte_full_nxt = 1'b0;
                        if (state == ST_ADDR) begin
                            if (shreg[7:1] == TARGET_ADDR && !shreg[0]) begin
                                sda_oe_nxt = 1'b1;
                                state_nxt  = ST_ADDR_ACK;
                            end else begin
                                state_nxt  = ST_IGNORE;
                            end
                        end else if (rx_ready) begin
                            rx_data_nxt  = shreg;
                            rx_valid_nxt = 1'b1;
                            sda_oe_nxt   = 1'b1;
                            state_nxt    = ST_DATA_ACK;
                        end else begin
                            state_nxt    = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt     = 1'b0;
                        addr_match_nxt = 1'b1;
                        bit_cnt_nxt    = '0;
                        state_nxt      = ST_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = ST_DATA;
                    end
                end
                ST_IGNORE: sda_oe_nxt = 1'b0;
                default:   ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_target_rx.sv
module tb_i2c_target_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       busy;
    logic       addr_match;

    int n_tests = 0;
    int n_fail  = 0;

    // Open-drain bus: either side may pull low.
    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_rx dut (
        .clk        (clk),
        .reset      (rst_n),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .addr_match (addr_match)
    );

    always #5 clk = ~clk;

    // Byte capture and pulse-width monitor.
    logic [7:0] got_q[$];
    logic       prev_valid = 1'b0;
    int         wide_err   = 0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            if (prev_valid) wide_err <= wide_err + 1;
        end
        prev_valid <= rx_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    localparam time Q = 100ns;

    task automatic bus_start();
        sda_m = 1'b1; scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic bus_bit(input logic b, output logic seen);
        sda_m = b; #Q;
        scl = 1'b1; #Q;
        seen = sda_bus; #Q;
        scl = 1'b0; #Q;
    endtask

    // Sends a byte MSB first and returns the bus level in the ACK slot.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], dummy);
        bus_bit(1'b1, ack);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nd;
        logic       rdy;
        logic       aack;
        logic       dack;
        int         nv;
        logic [7:0] last;
        logic       match;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic ack;
        logic [7:0] b;

        vecs[0] = '{8'h56, 8'h59, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1, 8'h59, 1'b1};
        vecs[1] = '{8'h54, 8'h59, 8'h00, 1, 1'b1, 1'b1, 1'b1, 0, 8'h59, 1'b0};
        vecs[2] = '{8'h57, 8'h00, 8'h00, 0, 1'b1, 1'b1, 1'b1, 0, 8'h59, 1'b0};
        vecs[3] = '{8'h56, 8'h3C, 8'h00, 1, 1'b1, 1'b0, 1'b0, 1, 8'h3C, 1'b1};
        vecs[4] = '{8'h56, 8'h59, 8'hA5, 2, 1'b0, 1'b0, 1'b1, 0, 8'h3C, 1'b1};

        rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_outputs", {sda_oe, rx_valid, busy, addr_match, rx_data}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("idle_busy", busy, 1'b0);

        for (int v = 0; v < 5; v++) begin
            got_q.delete();
            rx_ready = vecs[v].rdy;
            bus_start();
            chk($sformatf("v%0d_busy_start", v), busy, 1'b1);
            send_byte(vecs[v].a, ack);
            chk($sformatf("v%0d_addr_ack", v), ack, vecs[v].aack);
            for (int i = 0; i < vecs[v].nd; i++) begin
                b = (i == 0) ? vecs[v].d0 : vecs[v].d1;
                send_byte(b, ack);
                chk($sformatf("v%0d_data%0d_ack", v, i), ack, vecs[v].dack);
            end
            chk($sformatf("v%0d_addr_match", v), addr_match, vecs[v].match);
            chk($sformatf("v%0d_busy_pre_stop", v), busy, 1'b1);
            bus_stop();
            chk($sformatf("v%0d_busy_post_stop", v), busy, 1'b0);
            chk($sformatf("v%0d_match_post_stop", v), addr_match, 1'b0);
            chk($sformatf("v%0d_sda_oe_post_stop", v), sda_oe, 1'b0);
            chk($sformatf("v%0d_nvalid", v), got_q.size(), vecs[v].nv);
            chk($sformatf("v%0d_rx_data", v), rx_data, vecs[v].last);
        end

        // Two bytes, repeated START, third byte.
        got_q.delete();
        rx_ready = 1'b1;
        bus_start();
        send_byte(8'h56, ack); chk("rs_addr1_ack", ack, 1'b0);
        send_byte(8'h59, ack); chk("rs_d59_ack", ack, 1'b0);
        send_byte(8'h3C, ack); chk("rs_d3c_ack", ack, 1'b0);
        bus_rstart();
        chk("rs_match_cleared", addr_match, 1'b0);
        chk("rs_busy_held", busy, 1'b1);
        send_byte(8'h56, ack); chk("rs_addr2_ack", ack, 1'b0);
        send_byte(8'h81, ack); chk("rs_d81_ack", ack, 1'b0);
        bus_stop();
        chk("rs_nvalid", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("rs_byte0", got_q[0], 8'h59);
            chk("rs_byte1", got_q[1], 8'h3C);
            chk("rs_byte2", got_q[2], 8'h81);
        end

        // Reset in the middle of a data byte.
        got_q.delete();
        bus_start();
        send_byte(8'h56, ack); chk("mr_addr_ack", ack, 1'b0);
        for (int i = 7; i >= 4; i--) begin
            logic dummy;
            b = 8'h59;
            bus_bit(b[i], dummy);
        end
        chk("mr_match_before", addr_match, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_reset_outputs", {sda_oe, rx_valid, busy, addr_match, rx_data}, 32'h0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("mr_busy_after_release", busy, 1'b0);
        bus_stop();
        bus_start();
        send_byte(8'h56, ack); chk("mr2_addr_ack", ack, 1'b0);
        send_byte(8'h59, ack); chk("mr2_data_ack", ack, 1'b0);
        bus_stop();
        chk("mr2_nvalid", got_q.size(), 1);
        chk("mr2_rx_data", rx_data, 8'h59);
        chk("mr2_busy", busy, 1'b0);

        chk("valid_width", wide_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
